// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the framed UART transmitter.
// States walk one byte through the UART handshake; the phase picks which frame byte is sent.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_WAIT_BUSY,
        ST_WAIT_IDLE,
        ST_NEXT
    } txState_t;

    typedef enum logic [1:0] {
        PH_HDR,
        PH_LEN,
        PH_PAY,
        PH_CHK
    } txPhase_t;

    localparam logic [7:0] DEFAULT_HEADER = 8'hAA;
    localparam int         SETUP_CYC      = 3;

endpackage

// File: rtl/uart_byte_fifo.sv
// First-word-fall-through byte FIFO with level output and a synchronous flush.
// Writes while full are dropped; a write and a pop in the same cycle both take effect.
module uart_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    input  logic                   iWR,
    input  logic [7:0]             iWDATA,
    input  logic                   iRD,
    input  logic                   iFLUSH,
    output logic [7:0]             oRDATA,
    output logic [$clog2(DEPTH):0] oCNT,
    output logic                   oFULL
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic          wrEn;
    logic          rdEn;
    logic          empty;

    assign oFULL  = (oCNT == CW'(DEPTH));
    assign empty  = (oCNT == '0);
    assign wrEn   = iWR && !oFULL && !iFLUSH;
    assign rdEn   = iRD && !empty;
    assign oRDATA = mem[rdPtr];

    always_ff @(posedge iCLK) begin
        if (!iRST && wrEn) begin
            mem[wrPtr] <= iWDATA;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST || iFLUSH) begin
            wrPtr <= '0;
            rdPtr <= '0;
            oCNT  <= '0;
        end else begin
            if (wrEn) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (rdEn) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (wrEn && !rdEn) begin
                oCNT <= oCNT + 1'b1;
            end else if (rdEn && !wrEn) begin
                oCNT <= oCNT - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_frame_tx.sv
// Sends HEADER, LEN, LEN payload bytes from the FIFO, then CHK = LEN + payload sum,
// handing each byte to a UART through a request / done handshake with a wait timeout.
module uart_frame_tx
    import uart_frame_pkg::*;
#(
    parameter int         FIFO_DEPTH  = 16,
    parameter logic [7:0] HEADER      = DEFAULT_HEADER,
    parameter int         REQ_HOLD    = 4,
    parameter int         TIMEOUT_CYC = 4096
) (
    input  logic                        iCLK,
    input  logic                        iRST,
    input  logic                        iWR,
    input  logic [7:0]                  iWDATA,
    input  logic                        iSEND,
    input  logic                        iT_DONE,
    output logic                        oT_REQ,
    output logic [7:0]                  oT_DATA,
    output logic                        oFULL,
    output logic [$clog2(FIFO_DEPTH):0] oCNT,
    output logic                        oBUSY,
    output logic                        oDONE,
    output logic                        oERR
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = $clog2(TIMEOUT_CYC + REQ_HOLD + SETUP_CYC + 1);

    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(REQ_HOLD - 1);
    localparam logic [CW-1:0] WAIT_LAST  = CW'(TIMEOUT_CYC - 1);

    txState_t      state, stateNext;
    txPhase_t      phase, phaseNext;
    logic [7:0]    dataReg, dataNext;
    logic [7:0]    chkReg, chkNext;
    logic [7:0]    lenReg, lenNext;
    logic [LW-1:0] payLeft, payLeftNext;
    logic [CW-1:0] cycCnt, cntNext;
    logic [7:0]    fifoData;
    logic          fifoPop;
    logic          fifoFlush;
    logic          timedOut;

    uart_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) payloadFifo (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .iWR    (iWR),
        .iWDATA (iWDATA),
        .iRD    (fifoPop),
        .iFLUSH (fifoFlush),
        .oRDATA (fifoData),
        .oCNT   (oCNT),
        .oFULL  (oFULL)
    );

    assign oBUSY   = (state != ST_IDLE);
    assign oT_REQ  = (state == ST_STROBE);
    assign oT_DATA = dataReg;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state   <= ST_IDLE;
            phase   <= PH_HDR;
            dataReg <= '0;
            chkReg  <= '0;
            lenReg  <= '0;
            payLeft <= '0;
            cycCnt  <= '0;
        end else begin
            state   <= stateNext;
            phase   <= phaseNext;
            dataReg <= dataNext;
            chkReg  <= chkNext;
            lenReg  <= lenNext;
            payLeft <= payLeftNext;
            cycCnt  <= cntNext;
        end
    end

    // dataReg is loaded on the way into SETUP so the byte is already on the bus in its first cycle
    always_comb begin
        stateNext   = state;
        phaseNext   = phase;
        dataNext    = dataReg;
        chkNext     = chkReg;
        lenNext     = lenReg;
        payLeftNext = payLeft;
        cntNext     = cycCnt + 1'b1;
        fifoPop     = 1'b0;
        fifoFlush   = 1'b0;
        timedOut    = 1'b0;
        oDONE       = 1'b0;

        case (state)
            ST_IDLE: begin
                cntNext = '0;
                if (iSEND) begin
                    stateNext   = ST_SETUP;
                    phaseNext   = PH_HDR;
                    dataNext    = HEADER;
                    lenNext     = 8'(oCNT);
                    payLeftNext = oCNT;
                    chkNext     = 8'(oCNT);
                end
            end
            ST_SETUP: begin
                if (cycCnt == '0 && phase == PH_PAY) begin
                    fifoPop     = 1'b1;
                    chkNext     = chkReg + dataReg;
                    payLeftNext = payLeft - 1'b1;
                end
                if (cycCnt == SETUP_LAST) begin
                    stateNext = ST_STROBE;
                    cntNext   = '0;
                end
            end
            ST_STROBE: begin
                if (cycCnt == HOLD_LAST) begin
                    stateNext = ST_WAIT_BUSY;
                    cntNext   = '0;
                end
            end
            ST_WAIT_BUSY: begin
                if (!iT_DONE) begin
                    stateNext = ST_WAIT_IDLE;
                    cntNext   = '0;
                end else if (cycCnt == WAIT_LAST) begin
                    timedOut = 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                if (iT_DONE) begin
                    stateNext = ST_NEXT;
                    cntNext   = '0;
                end else if (cycCnt == WAIT_LAST) begin
                    timedOut = 1'b1;
                end
            end
            ST_NEXT: begin
                cntNext   = '0;
                stateNext = ST_SETUP;
                case (phase)
                    PH_HDR: begin
                        phaseNext = PH_LEN;
                        dataNext  = lenReg;
                    end
                    PH_LEN, PH_PAY: begin
                        if (payLeft == '0) begin
                            phaseNext = PH_CHK;
                            dataNext  = chkReg;
                        end else begin
                            phaseNext = PH_PAY;
                            dataNext  = fifoData;
                        end
                    end
                    default: begin
                        stateNext = ST_IDLE;
                        phaseNext = PH_HDR;
                        oDONE     = 1'b1;
                    end
                endcase
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase

        // A stalled UART abandons the frame and discards everything queued
        if (timedOut) begin
            stateNext = ST_IDLE;
            phaseNext = PH_HDR;
            cntNext   = '0;
            fifoFlush = 1'b1;
        end
    end

    assign oERR = timedOut;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx: a vector table for reset/fill/setup timing plus
// hand-written frame sequences checked against a behavioural UART that logs every requested byte.
module tb_uart_frame_tx;

    localparam int TO   = 4096;
    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       send = 1'b0;
    logic       tDone = 1'b1;
    logic       oT_REQ;
    logic [7:0] oT_DATA;
    logic       oFULL;
    logic [4:0] oCNT;
    logic       oBUSY;
    logic       oDONE;
    logic       oERR;

    uart_frame_tx #(
        .FIFO_DEPTH  (16),
        .HEADER      (8'hAA),
        .REQ_HOLD    (HOLD),
        .TIMEOUT_CYC (TO)
    ) dut (
        .iCLK    (clk),
        .iRST    (rst),
        .iWR     (wr),
        .iWDATA  (wdata),
        .iSEND   (send),
        .iT_DONE (tDone),
        .oT_REQ  (oT_REQ),
        .oT_DATA (oT_DATA),
        .oFULL   (oFULL),
        .oCNT    (oCNT),
        .oBUSY   (oBUSY),
        .oDONE   (oDONE),
        .oERR    (oERR)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       wr;
        logic [7:0] wdata;
        logic       send;
        logic [4:0] expCnt;
        logic       expFull;
        logic       expBusy;
        logic       expReq;
        logic [7:0] expData;
    } vec_t;

    vec_t       vecs [9];
    logic [7:0] txLog [$];
    logic [7:0] expQ [$];
    int checkCount = 0;
    int passCount  = 0;
    int reqRises   = 0;
    int doneCount  = 0;
    int errCount   = 0;
    int holdErr    = 0;
    int stableErr  = 0;
    logic uartStuck = 1'b0;

    // Behavioural UART: drops done two cycles after a request edge, raises it eight cycles later
    logic       reqPrev = 1'b0;
    int         reqRun = 0;
    logic       uartActive = 1'b0;
    int         uartTimer = 0;
    logic [7:0] curByte = 8'h00;

    always @(negedge clk) begin
        if (oDONE) doneCount++;
        if (oERR) errCount++;
        if (rst) begin
            uartActive = 1'b0;
            uartTimer  = 0;
            tDone      = 1'b1;
            reqPrev    = 1'b0;
            reqRun     = 0;
        end else begin
            if (oT_REQ) begin
                reqRun++;
            end else begin
                if (reqRun != 0 && reqRun != HOLD) holdErr++;
                reqRun = 0;
            end
            if (oT_REQ && !reqPrev) begin
                reqRises++;
                if (!uartStuck) begin
                    txLog.push_back(oT_DATA);
                    curByte    = oT_DATA;
                    uartActive = 1'b1;
                    uartTimer  = 0;
                end
            end
            if (uartActive) begin
                if (oT_DATA !== curByte) stableErr++;
                uartTimer++;
                if (uartTimer == 2) begin
                    tDone = 1'b0;
                end else if (uartTimer == 10) begin
                    tDone      = 1'b1;
                    uartActive = 1'b0;
                end
            end
            reqPrev = oT_REQ;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        rst   = v.rst;
        wr    = v.wr;
        wdata = v.wdata;
        send  = v.send;
        step();
        checkOutput($sformatf("vector %0d {cnt,full,busy,req,data}", idx),
                    {oCNT, oFULL, oBUSY, oT_REQ, oT_DATA},
                    {v.expCnt, v.expFull, v.expBusy, v.expReq, v.expData});
    endtask

    task automatic writeByte(input logic [7:0] b);
        wr    = 1'b1;
        wdata = b;
        step();
        wr    = 1'b0;
    endtask

    task automatic pulseSend();
        send = 1'b1;
        step();
        send = 1'b0;
    endtask

    task automatic waitDone(input string name, input int budget);
        int start;
        int n;
        start = doneCount;
        n = 0;
        while (doneCount == start && n < budget) begin
            step();
            n++;
        end
        checkOutput({name, " oDONE pulses"}, doneCount - start, 1);
    endtask

    task automatic checkFrame(input string name);
        int bad;
        bad = 0;
        checkOutput({name, " length"}, txLog.size(), expQ.size());
        for (int i = 0; i < expQ.size(); i++) begin
            if (i >= txLog.size() || txLog[i] !== expQ[i]) bad++;
        end
        checkOutput({name, " wrong bytes"}, bad, 0);
    endtask

    initial begin
        int r0;
        int d0;
        int e0;
        int n;
        int waitLen;

        //          rst   wr    wdata  send  cnt    full  busy  req   data
        vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 1'b1, 8'h01, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[2] = '{1'b0, 1'b1, 8'h02, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[3] = '{1'b0, 1'b1, 8'h03, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 8'hAA};
        vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 8'hAA};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, 8'hAA};
        vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1, 8'hAA};
        vecs[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd3, 1'b0, 1'b1, 1'b1, 8'hAA};

        repeat (2) step();
        checkOutput("reset {done,err}", {oDONE, oERR}, 2'b00);

        // Frame 01,02,03: the table starts it, CHK = 3 + 1 + 2 + 3 = 09
        r0 = reqRises;
        for (int i = 0; i < 9; i++) applyStimulus(vecs[i], i);
        waitDone("frame 010203", 2000);
        expQ.delete();
        expQ.push_back(8'hAA); expQ.push_back(8'h03); expQ.push_back(8'h01);
        expQ.push_back(8'h02); expQ.push_back(8'h03); expQ.push_back(8'h09);
        checkFrame("frame 010203");
        checkOutput("frame 010203 request edges", reqRises - r0, 6);
        checkOutput("frame 010203 {cnt,busy}", {oCNT, oBUSY}, 6'd0);

        // Empty frame
        txLog.delete();
        r0 = reqRises;
        pulseSend();
        waitDone("empty frame", 2000);
        expQ.delete();
        expQ.push_back(8'hAA); expQ.push_back(8'h00); expQ.push_back(8'h00);
        checkFrame("empty frame");
        checkOutput("empty frame request edges", reqRises - r0, 3);

        // Fill past capacity: the 17th byte (50) is dropped
        txLog.delete();
        for (int i = 0; i < 17; i++) begin
            writeByte(8'(8'h40 + i));
            if (i == 15) checkOutput("{full,cnt} after 16 writes", {oFULL, oCNT}, {1'b1, 5'd16});
            if (i == 16) checkOutput("{full,cnt} after 17 writes", {oFULL, oCNT}, {1'b1, 5'd16});
        end
        pulseSend();
        waitDone("full frame", 4000);
        expQ.delete();
        expQ.push_back(8'hAA); expQ.push_back(8'h10);
        for (int i = 0; i < 16; i++) expQ.push_back(8'(8'h40 + i));
        expQ.push_back(8'h88);
        checkFrame("full frame");
        checkOutput("full frame {full,cnt} after", {oFULL, oCNT}, 6'd0);

        // FF,FF wraps CHK to 00; a send pulse and a write during the frame must not join it
        writeByte(8'hFF);
        writeByte(8'hFF);
        txLog.delete();
        r0 = reqRises;
        pulseSend();
        repeat (20) step();
        pulseSend();
        writeByte(8'h33);
        waitDone("FFFF frame", 2000);
        d0 = doneCount;
        repeat (80) step();
        checkOutput("no second frame oDONE", doneCount - d0, 0);
        expQ.delete();
        expQ.push_back(8'hAA); expQ.push_back(8'h02); expQ.push_back(8'hFF);
        expQ.push_back(8'hFF); expQ.push_back(8'h00);
        checkFrame("FFFF frame");
        checkOutput("FFFF frame request edges", reqRises - r0, 5);
        checkOutput("late write stays queued cnt", oCNT, 5'd1);

        // UART never answers: timeout after TO cycles in WAIT_BUSY flushes the FIFO
        writeByte(8'h44);
        uartStuck = 1'b1;
        e0 = errCount;
        d0 = doneCount;
        pulseSend();
        n = 0;
        while (oT_REQ !== 1'b1 && n < 50) begin step(); n++; end
        while (oT_REQ !== 1'b0 && n < 50) begin step(); n++; end
        waitLen = 1;
        while (oERR !== 1'b1 && waitLen < TO + 50) begin step(); waitLen++; end
        checkOutput("timeout wait cycles", waitLen, TO);
        step();
        checkOutput("after timeout {cnt,busy,req,err}", {oCNT, oBUSY, oT_REQ, oERR}, 8'd0);
        checkOutput("timeout oERR pulses", errCount - e0, 1);
        checkOutput("timeout oDONE pulses", doneCount - d0, 0);
        uartStuck = 1'b0;

        // Reset in the middle of the payload, then a clean 1-byte frame
        txLog.delete();
        writeByte(8'hA1);
        writeByte(8'hA2);
        writeByte(8'hA3);
        r0 = reqRises;
        pulseSend();
        n = 0;
        while (reqRises - r0 < 3 && n < 200) begin step(); n++; end
        checkOutput("reached first payload strobe", reqRises - r0, 3);
        checkOutput("cnt after first pop", oCNT, 5'd2);
        rst = 1'b1;
        step();
        checkOutput("reset mid-frame outputs", {oCNT, oFULL, oBUSY, oT_REQ, oT_DATA, oDONE, oERR}, 18'd0);
        rst = 1'b0;
        r0 = reqRises;
        d0 = doneCount;
        repeat (40) step();
        checkOutput("no requests after reset", reqRises - r0, 0);
        checkOutput("no oDONE after reset", doneCount - d0, 0);
        txLog.delete();
        writeByte(8'h7F);
        r0 = reqRises;
        pulseSend();
        waitDone("7F frame", 2000);
        expQ.delete();
        expQ.push_back(8'hAA); expQ.push_back(8'h01); expQ.push_back(8'h7F); expQ.push_back(8'h80);
        checkFrame("7F frame");
        checkOutput("7F frame request edges", reqRises - r0, 4);

        checkOutput("oT_REQ high-run length errors", holdErr, 0);
        checkOutput("oT_DATA stability errors", stableErr, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
